// File: rtl/stopwatch_lap_if.sv
// Key-pulse inputs and display/lap outputs of the stopwatch lap core, grouped as one bundle.
// master = pulse generators / display side, slave = stopwatch_lap_core.
interface stopwatch_lap_if #(
  parameter int unsigned MIN_DIGITS = 2,
  parameter int unsigned LAP_DEPTH  = 4
);
  localparam int unsigned TW = 16 + 4 * MIN_DIGITS;
  localparam int unsigned CW = $clog2(LAP_DEPTH) + 1;

  logic          start_pulse;
  logic          pause_pulse;
  logic          clear_pulse;
  logic          lap_pulse;
  logic          lap_rd_pulse;
  logic          count_down;
  logic [TW-1:0] preset_bcd;

  logic [TW-1:0] time_bcd;
  logic          running;
  logic          alarm;
  logic          tick_10ms;
  logic [TW-1:0] lap_bcd;
  logic [CW-1:0] lap_count;
  logic          lap_overflow;

  modport master (
    output start_pulse, pause_pulse, clear_pulse, lap_pulse, lap_rd_pulse, count_down,
    output preset_bcd,
    input  time_bcd, running, alarm, tick_10ms, lap_bcd, lap_count, lap_overflow
  );

  modport slave (
    input  start_pulse, pause_pulse, clear_pulse, lap_pulse, lap_rd_pulse, count_down,
    input  preset_bcd,
    output time_bcd, running, alarm, tick_10ms, lap_bcd, lap_count, lap_overflow
  );
endinterface

// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: control FSM, 10 ms prescaler, BCD time counter and lap FIFO in one domain.
// Optional countdown mode is enabled by defining COUNTDOWN_EN.
module stopwatch_lap_core #(
  parameter int unsigned CLK_DIV    = 1_000_000,
  parameter int unsigned MIN_DIGITS = 2,
  parameter int unsigned LAP_DEPTH  = 4
) (
  input logic           clk,
  input logic           reset,
  stopwatch_lap_if.slave bus
);
  localparam int unsigned TW = 16 + 4 * MIN_DIGITS;
  localparam int unsigned ND = 4 + MIN_DIGITS;
  localparam int unsigned CW = $clog2(LAP_DEPTH) + 1;
  localparam int unsigned AW = $clog2(LAP_DEPTH);
  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  // Seconds-tens is the only digit that wraps at 5.
  function automatic logic [3:0] digit_max(input int i);
    return (i == 3) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [TW-1:0] limit_word();
    logic [TW-1:0] w;
    w = '0;
    for (int i = 0; i < int'(ND); i++) w[4*i +: 4] = digit_max(i);
    return w;
  endfunction

  localparam logic [TW-1:0] LIMIT = limit_word();

  // One BCD increment or decrement with digit-wise carry/borrow ripple.
  function automatic logic [TW-1:0] bcd_step(input logic [TW-1:0] t, input logic down);
    logic [TW-1:0] r;
    logic          c;
    logic [3:0]    d;
    logic [3:0]    mx;
    r = t;
    c = 1'b1;
    for (int i = 0; i < int'(ND); i++) begin
      d  = t[4*i +: 4];
      mx = digit_max(i);
      if (c) begin
        if (!down) begin
          if (d >= mx) begin
            d = 4'd0;
            c = 1'b1;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = mx;
            c = 1'b1;
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] bcd_clamp(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    r = t;
    for (int i = 0; i < int'(ND); i++) begin
      if (t[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] time_q, time_d;
  logic          mode_q, mode_d;
  logic          loaded_q, loaded_d;

  logic          cd_in;
  logic [TW-1:0] preset_w;
  logic          tick;
  logic [TW-1:0] step_w;
  logic [TW-1:0] goal_w;
  logic [TW-1:0] start_val;

`ifdef COUNTDOWN_EN
  assign cd_in    = bus.count_down;
  assign preset_w = bcd_clamp(bus.preset_bcd);
`else
  logic unused_cd;
  assign cd_in     = 1'b0;
  assign preset_w  = '0;
  assign unused_cd = ^{bus.count_down, bus.preset_bcd, bcd_clamp('0)};
`endif

  assign tick      = (state_q == StRun) && (presc_q == PRESC_MAX);
  assign step_w    = bcd_step(time_q, mode_q);
  assign goal_w    = mode_q ? '0 : LIMIT;
  // After reset no preset has been loaded yet, so a countdown start takes it directly.
  assign start_val = loaded_q ? time_q : preset_w;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    time_d   = time_q;
    mode_d   = mode_q;
    loaded_d = loaded_q;
    if (bus.clear_pulse) begin
      state_d  = StIdle;
      presc_d  = '0;
      time_d   = cd_in ? preset_w : '0;
      loaded_d = cd_in;
      mode_d   = cd_in;
    end else begin
      unique case (state_q)
        StIdle: begin
          mode_d = cd_in;
          if (bus.start_pulse) begin
            if (cd_in) begin
              time_d  = start_val;
              state_d = (start_val == '0) ? StAlarm : StRun;
            end else begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (tick) begin
            presc_d = '0;
            time_d  = step_w;
            if (step_w == goal_w) state_d = StAlarm;
            else if (bus.pause_pulse) state_d = StPause;
          end else begin
            presc_d = presc_q + PW'(1);
            if (bus.pause_pulse) state_d = StPause;
          end
        end
        StPause: begin
          if (bus.start_pulse) state_d = StRun;
        end
        StAlarm: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      time_q   <= '0;
      mode_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      mode_q   <= mode_d;
      loaded_q <= loaded_d;
    end
  end

  // Lap FIFO
  logic [TW-1:0] lap_mem [LAP_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          lap_acc, do_pop, do_wr, lap_drop, fifo_full;

  assign fifo_full = (cnt_q == CW'(LAP_DEPTH));
  assign lap_acc   = bus.lap_pulse && ((state_q == StRun) || (state_q == StPause));
  assign do_pop    = bus.lap_rd_pulse && (cnt_q != '0);
  // A pop in the same cycle frees the slot the new lap goes into.
  assign do_wr     = lap_acc && (!fifo_full || do_pop);
  assign lap_drop  = lap_acc && fifo_full && !do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < int'(LAP_DEPTH); i++) lap_mem[i] <= '0;
    end else if (bus.clear_pulse) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_wr) begin
        lap_mem[wr_q] <= time_q;
        wr_q          <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      if (do_wr && !do_pop) cnt_q <= cnt_q + CW'(1);
      else if (!do_wr && do_pop) cnt_q <= cnt_q - CW'(1);
      if (lap_drop) ovf_q <= 1'b1;
    end
  end

  assign bus.time_bcd     = time_q;
  assign bus.running      = (state_q == StRun);
  assign bus.alarm        = (state_q == StAlarm);
  assign bus.tick_10ms    = tick;
  assign bus.lap_bcd      = (cnt_q == '0) ? '0 : lap_mem[rd_q];
  assign bus.lap_count    = cnt_q;
  assign bus.lap_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Randomised bench for stopwatch_lap_core against a centisecond/queue reference model.
module tb_stopwatch_lap_core;
  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned MIN_DIGITS = 1;
  localparam int unsigned LAP_DEPTH  = 4;
  localparam int CDIV     = 4;
  localparam int DEPTH    = 4;
  localparam int LIMIT_CS = 59999;
  localparam int SIdle = 0, SRun = 1, SPause = 2, SAlarm = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  stopwatch_lap_if #(.MIN_DIGITS(MIN_DIGITS), .LAP_DEPTH(LAP_DEPTH)) bus ();

  stopwatch_lap_core #(
    .CLK_DIV   (CLK_DIV),
    .MIN_DIGITS(MIN_DIGITS),
    .LAP_DEPTH (LAP_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: whole centiseconds, run-cycle phase, lap queue.
  int   m_state, m_phase, m_cs;
  int   m_q[$];
  bit   m_ovf;
  int   dut_ticks, mdl_ticks, tick_err;
  logic [19:0] forced;

  function automatic logic [19:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic void model_reset();
    m_state = SIdle;
    m_phase = 0;
    m_cs    = 0;
    m_q.delete();
    m_ovf   = 1'b0;
  endfunction

  function automatic void model_step(bit st, bit pa, bit cl, bit lp, bit rd, bit tk);
    if (cl) begin
      model_reset();
      return;
    end
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (lp && (m_state == SRun || m_state == SPause)) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_cs);
      else m_ovf = 1'b1;
    end
    case (m_state)
      SIdle:  if (st) m_state = SRun;
      SRun: begin
        if (tk) begin
          m_phase = 0;
          m_cs++;
          if (m_cs == LIMIT_CS) m_state = SAlarm;
          else if (pa) m_state = SPause;
        end else begin
          m_phase++;
          if (pa) m_state = SPause;
        end
      end
      SPause: if (st) m_state = SRun;
      default: ;
    endcase
  endfunction

  task automatic cycle(input bit st, input bit pa, input bit cl, input bit lp, input bit rd);
    bit exp_tick;
    @(negedge clk);
    exp_tick = (m_state == SRun) && (m_phase == CDIV - 1);
    if (bus.tick_10ms === 1'b1) dut_ticks++;
    if (exp_tick) mdl_ticks++;
    if (bus.tick_10ms !== exp_tick) tick_err++;
    bus.start_pulse  = st;
    bus.pause_pulse  = pa;
    bus.clear_pulse  = cl;
    bus.lap_pulse    = lp;
    bus.lap_rd_pulse = rd;
    model_step(st, pa, cl, lp, rd, exp_tick);
    @(posedge clk);
    #1;
    bus.start_pulse  = 1'b0;
    bus.pause_pulse  = 1'b0;
    bus.clear_pulse  = 1'b0;
    bus.lap_pulse    = 1'b0;
    bus.lap_rd_pulse = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    int target, guard;
    target = mdl_ticks + n;
    guard  = 0;
    while (mdl_ticks < target && guard < n * CDIV + 8) begin
      cycle(0, 0, 0, 0, 0);
      guard++;
    end
    if (mdl_ticks < target) begin
      total++; bad++;
      $display("FAIL run_ticks_timeout got=%0d want=%0d", mdl_ticks, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.time_bcd !== 20'h0) begin bad++;
      $display("FAIL rst_time got=%h want=%h", bus.time_bcd, 20'h0); end
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    total++; if (bus.time_bcd !== 20'h0) begin bad++;
      $display("FAIL rst_time2 got=%h want=%h", bus.time_bcd, 20'h0); end
    total++; if (bus.running !== 1'b0) begin bad++;
      $display("FAIL rst_running got=%b want=0", bus.running); end
    total++; if (bus.alarm !== 1'b0) begin bad++;
      $display("FAIL rst_alarm got=%b want=0", bus.alarm); end
    total++; if (bus.tick_10ms !== 1'b0) begin bad++;
      $display("FAIL rst_tick got=%b want=0", bus.tick_10ms); end
    total++; if (bus.lap_bcd !== 20'h0) begin bad++;
      $display("FAIL rst_lap_bcd got=%h want=0", bus.lap_bcd); end
    total++; if (bus.lap_count !== 3'd0) begin bad++;
      $display("FAIL rst_lap_count got=%0d want=0", bus.lap_count); end
    total++; if (bus.lap_overflow !== 1'b0) begin bad++;
      $display("FAIL rst_overflow got=%b want=0", bus.lap_overflow); end
  endtask

  task automatic test_run_second();
    int t0;
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    t0 = dut_ticks;
    tick_err = 0;
    repeat (400) cycle(0, 0, 0, 0, 0);
    total++; if (bus.time_bcd !== 20'h00100 || bus.time_bcd !== to_bcd(m_cs)) begin bad++;
      $display("FAIL run_time got=%h want=%h", bus.time_bcd, 20'h00100); end
    total++; if (dut_ticks - t0 !== 100) begin bad++;
      $display("FAIL run_tick_count got=%0d want=100", dut_ticks - t0); end
    total++; if (tick_err !== 0) begin bad++;
      $display("FAIL run_tick_timing got=%0d want=0", tick_err); end
    total++; if (bus.running !== 1'b1) begin bad++;
      $display("FAIL run_running got=%b want=1", bus.running); end
  endtask

  task automatic test_pause_resume();
    int t0;
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    tick_err = 0;
    run_ticks(10);
    cycle(0, 1, 0, 0, 0);
    t0 = dut_ticks;
    repeat (20) cycle(0, 0, 0, 0, 0);
    total++; if (bus.time_bcd !== 20'h00010 || dut_ticks !== t0) begin bad++;
      $display("FAIL pause_hold got=%h/%0d want=%h/%0d", bus.time_bcd, dut_ticks, 20'h10, t0); end
    total++; if (bus.running !== 1'b0) begin bad++;
      $display("FAIL pause_running got=%b want=0", bus.running); end
    cycle(1, 0, 0, 0, 0);
    run_ticks(2);
    total++; if (bus.time_bcd !== 20'h00012) begin bad++;
      $display("FAIL resume_time got=%h want=%h", bus.time_bcd, 20'h00012); end
    // Random pause/resume episodes at arbitrary prescaler phases.
    for (int e = 0; e < 8; e++) begin
      repeat ($urandom_range(1, 11)) cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      repeat ($urandom_range(0, 9)) cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
    end
    repeat ($urandom_range(1, 7)) cycle(0, 0, 0, 0, 0);
    total++; if (bus.time_bcd !== to_bcd(m_cs)) begin bad++;
      $display("FAIL episode_time got=%h want=%h", bus.time_bcd, to_bcd(m_cs)); end
    total++; if (tick_err !== 0) begin bad++;
      $display("FAIL episode_tick_timing got=%0d want=0", tick_err); end
  endtask

  task automatic test_laps();
    int cap[5];
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      run_ticks(int'($urandom_range(1, 3)));
      cap[k] = m_cs;
      cycle(0, 0, 0, 1, 0);
    end
    total++; if (bus.lap_count !== 3'd4) begin bad++;
      $display("FAIL lap_count_full got=%0d want=4", bus.lap_count); end
    total++; if (bus.lap_overflow !== 1'b1) begin bad++;
      $display("FAIL lap_overflow got=%b want=1", bus.lap_overflow); end
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.lap_bcd !== to_bcd(cap[i])) begin bad++;
        $display("FAIL lap_read%0d got=%h want=%h", i, bus.lap_bcd, to_bcd(cap[i])); end
      cycle(0, 0, 0, 0, 1);
    end
    total++; if (bus.lap_bcd !== 20'h0 || bus.lap_count !== 3'd0) begin bad++;
      $display("FAIL lap_empty got=%h/%0d want=0/0", bus.lap_bcd, bus.lap_count); end
    cycle(0, 0, 0, 0, 1);
    total++; if (bus.lap_count !== 3'd0 || bus.lap_overflow !== 1'b1) begin bad++;
      $display("FAIL lap_rd_empty got=%0d/%b want=0/1", bus.lap_count, bus.lap_overflow); end
  endtask

  task automatic test_random_mix();
    bit st, pa, cl, lp, rd;
    logic [19:0] exp_lap;
    cycle(0, 0, 1, 0, 0);
    for (int n = 0; n < 300; n++) begin
      st = ($urandom_range(0, 5) == 0);
      pa = ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 79) == 0);
      lp = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) == 0);
      cycle(st, pa, cl, lp, rd);
      exp_lap = (m_q.size() > 0) ? to_bcd(m_q[0]) : 20'h0;
      total++; if (bus.time_bcd !== to_bcd(m_cs)) begin bad++;
        $display("FAIL mix_time n=%0d got=%h want=%h", n, bus.time_bcd, to_bcd(m_cs)); end
      total++; if (bus.running !== (m_state == SRun)) begin bad++;
        $display("FAIL mix_running n=%0d got=%b want=%b", n, bus.running, m_state == SRun); end
      total++; if (bus.lap_count !== 3'(m_q.size())) begin bad++;
        $display("FAIL mix_lap_count n=%0d got=%0d want=%0d", n, bus.lap_count, m_q.size()); end
      total++; if (bus.lap_bcd !== exp_lap) begin bad++;
        $display("FAIL mix_lap_bcd n=%0d got=%h want=%h", n, bus.lap_bcd, exp_lap); end
      total++; if (bus.lap_overflow !== m_ovf) begin bad++;
        $display("FAIL mix_overflow n=%0d got=%b want=%b", n, bus.lap_overflow, m_ovf); end
    end
  endtask

  task automatic test_alarm();
    int guard, t0;
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    run_ticks(3);
    cycle(0, 1, 0, 0, 0);
    forced = to_bcd(59998);
    force dut.time_q = forced;
    cycle(0, 0, 0, 0, 0);
    release dut.time_q;
    m_cs = 59998;
    cycle(0, 0, 0, 0, 0);
    total++; if (bus.time_bcd !== 20'h95998) begin bad++;
      $display("FAIL alarm_preload got=%h want=%h", bus.time_bcd, 20'h95998); end
    cycle(1, 0, 0, 0, 0);
    guard = 0;
    while (m_state != SAlarm && guard < 2 * CDIV) begin
      cycle(0, 0, 0, 0, 0);
      guard++;
    end
    total++; if (bus.alarm !== 1'b1 || bus.running !== 1'b0) begin bad++;
      $display("FAIL alarm_state got=%b/%b want=1/0", bus.alarm, bus.running); end
    total++; if (bus.time_bcd !== 20'h95999) begin bad++;
      $display("FAIL alarm_time got=%h want=%h", bus.time_bcd, 20'h95999); end
    t0 = dut_ticks;
    cycle(1, 0, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0, 0);
    total++; if (bus.alarm !== 1'b1 || dut_ticks !== t0 || bus.time_bcd !== 20'h95999) begin
      bad++;
      $display("FAIL alarm_hold got=%b/%0d/%h want=1/%0d/%h", bus.alarm, dut_ticks, bus.time_bcd,
               t0, 20'h95999); end
    cycle(0, 0, 1, 0, 0);
    total++; if (bus.alarm !== 1'b0 || bus.running !== 1'b0 || bus.time_bcd !== 20'h0) begin
      bad++;
      $display("FAIL alarm_clear got=%b/%b/%h want=0/0/0", bus.alarm, bus.running, bus.time_bcd);
    end
  endtask

  task automatic test_clear_priority();
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, 0);
    run_ticks(3);
    cycle(1, 1, 1, 0, 0);
    total++; if (bus.running !== 1'b0 || bus.time_bcd !== 20'h0) begin bad++;
      $display("FAIL clr_state got=%b/%h want=0/0", bus.running, bus.time_bcd); end
    total++; if (bus.lap_count !== 3'd0 || bus.lap_overflow !== 1'b0 || bus.lap_bcd !== 20'h0)
    begin bad++;
      $display("FAIL clr_fifo got=%0d/%b/%h want=0/0/0", bus.lap_count, bus.lap_overflow,
               bus.lap_bcd); end
    repeat (8) cycle(0, 0, 0, 0, 0);
    total++; if (bus.time_bcd !== 20'h0 || bus.tick_10ms !== 1'b0) begin bad++;
      $display("FAIL clr_idle got=%h/%b want=0/0", bus.time_bcd, bus.tick_10ms); end
  endtask

  task automatic test_reset_midrun();
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    run_ticks(5);
    cycle(0, 0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.time_bcd !== 20'h0 || bus.running !== 1'b0 || bus.alarm !== 1'b0) begin
      bad++;
      $display("FAIL midrst_core got=%h/%b/%b want=0/0/0", bus.time_bcd, bus.running, bus.alarm);
    end
    total++; if (bus.tick_10ms !== 1'b0 || bus.lap_count !== 3'd0 || bus.lap_bcd !== 20'h0 ||
                 bus.lap_overflow !== 1'b0) begin bad++;
      $display("FAIL midrst_fifo got=%b/%0d/%h/%b want=0/0/0/0", bus.tick_10ms, bus.lap_count,
               bus.lap_bcd, bus.lap_overflow); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (4) cycle(0, 0, 0, 0, 0);
    total++; if (bus.time_bcd !== 20'h0 || bus.running !== 1'b0) begin bad++;
      $display("FAIL midrst_after got=%h/%b want=0/0", bus.time_bcd, bus.running); end
  endtask

`ifdef COUNTDOWN_EN
  task automatic test_countdown();
    bus.count_down = 1'b1;
    bus.preset_bcd = 20'h00003;
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (3 * CDIV) cycle(0, 0, 0, 0, 0);
    total++; if (bus.time_bcd !== 20'h0 || bus.alarm !== 1'b1) begin bad++;
      $display("FAIL countdown got=%h/%b want=0/1", bus.time_bcd, bus.alarm); end
    bus.count_down = 1'b0;
    bus.preset_bcd = '0;
  endtask
`endif

  initial begin
    bus.start_pulse  = 1'b0;
    bus.pause_pulse  = 1'b0;
    bus.clear_pulse  = 1'b0;
    bus.lap_pulse    = 1'b0;
    bus.lap_rd_pulse = 1'b0;
    bus.count_down   = 1'b0;
    bus.preset_bcd   = '0;
    dut_ticks = 0;
    mdl_ticks = 0;
    tick_err  = 0;
    model_reset();
    test_reset();
    test_run_second();
    test_pause_resume();
    test_laps();
    test_random_mix();
    test_alarm();
    test_clear_priority();
    test_reset_midrun();
`ifdef COUNTDOWN_EN
    test_countdown();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
